execute_muldiv: RTL and testbench
=================================

Name: execute_muldiv

Overview:
- Parametrised multi-cycle arithmetic execution unit: radix-2 iterative multiply, divide and remainder.
- Sits in parallel with the single-cycle execute path; register-writeback results go to the memory/writeback stage.
- Uses the same pipeline handshake as the execute stage: submit/ready, flush and next-ready.
- Adds behaviour the single-cycle stage lacks: width-generic operation, optional signed mode, abort-on-flush mid-operation, and output back-pressure holding.

Parameters:
- RW, 16, operand/result width in bits (>=4).
- REGNO, 8, number of architectural registers; width of the one-hot write-enable vector.
- SIGNED_EN, 1, 1 = i_signed honoured; 0 = i_signed ignored, always unsigned.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_submit  in  1  upstream offers an operation this cycle.
- o_ready  out  1  unit can accept an operation this cycle.
- i_flush  in  1  invalidate the offered and the in-flight operation.
- i_a  in  RW  left operand (multiplicand / dividend).
- i_b  in  RW  right operand (multiplier / divisor).
- i_mode  in  2  00 MUL low, 01 MUL high, 10 DIV quotient, 11 DIV remainder.
- i_signed  in  1  treat operands as two's complement.
- i_reg_ie  in  REGNO  one-hot destination register enable, carried with the operation.
- o_busy  out  1  operation in flight (state CALC or DONE).
- o_data  out  RW  result.
- o_reg_ie  out  REGNO  destination enable accompanying o_data.
- o_submit  out  1  one-cycle pulse: o_data/o_reg_ie valid for the next stage.
- i_next_ready  in  1  next stage can take a result.

Behaviour:
- Reset: state IDLE; o_submit=0, o_data=0, o_reg_ie=0, o_busy=0. Reset mid-operation discards the operation with no output.
- States:
  - IDLE: o_ready=1.
  - CALC: o_ready=0, performs iterations.
  - DONE: o_ready=0, holds the result.
- Accept: at an edge with state IDLE & i_submit & ~i_flush.
  - Latch operands, mode, sign and reg_ie.
  - Compute sign-corrected magnitudes: absolute values when signed, else raw.
  - Set iteration counter to RW; go to CALC.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
  - Internal 2*RW-bit accumulator.
  - Counter decrements; after the RW-th step go to DONE, so exactly RW CALC cycles.
- Divide by zero (latched i_b==0, DIV/REM): skip CALC and go straight to DONE.
  - Quotient = all ones.
  - Remainder = dividend, unmodified by sign handling.
- Sign fix-up (signed only), applied entering DONE:
  - Product negated if operand signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
  - MIN / -1 yields quotient MIN, remainder 0, with no special case.
- Result selection:
  - MUL low = product[RW-1:0].
  - MUL high = product[2RW-1:RW].
- DONE: at an edge where i_next_ready=1 and i_flush=0, register o_data/o_reg_ie, pulse o_submit=1 for one cycle, go to IDLE. Otherwise hold DONE indefinitely.
- Latency: with i_next_ready held high, o_submit is high in the cycle after edge RW+2 counted from the accept edge (divide-by-zero: after edge 2).
- o_submit is 0 in every cycle not immediately following a DONE→IDLE transition. o_data/o_reg_ie keep their last values otherwise.
- Flush:
  - i_flush in IDLE blocks acceptance.
  - i_flush in CALC or DONE returns to IDLE at that edge with no o_submit.
  - i_flush together with a DONE→IDLE transfer wins: no o_submit.
- New operations are accepted only from IDLE, so back-to-back acceptance is possible at the edge after o_submit's setup. Minimum issue interval is RW+2 cycles.
- o_busy = (state != IDLE).
- SIGNED_EN=0: sign logic is absent; i_signed is ignored.

Test Plan:
- RW=16, MUL low 0x1234*0x0010, i_next_ready=1 -> o_data=0x2340, o_reg_ie=input vector, o_submit one cycle after edge 18 following accept.
- MUL high unsigned 0xFFFF*0xFFFF -> 0xFFFE; same operands MUL low -> 0x0001; signed MUL high 0xFFFF*0xFFFF -> 0x0000.
- DIV 100/7 -> 14; REM -> 2; signed DIV -7/2 -> 0xFFFD; signed REM -> 0xFFFF; signed DIV 0x8000/0xFFFF -> 0x8000, REM 0x0000.
- DIV 0x1234/0 -> 0xFFFF; REM -> 0x1234; o_submit one cycle after edge 2, no CALC cycles.
- Accept DIV, assert i_flush at CALC cycle 5 -> IDLE next edge, no o_submit, o_ready=1. Then accept a new op: correct result, no stale data. i_flush simultaneous with i_submit in IDLE -> not accepted.
- Hold i_next_ready=0 for 10 cycles in DONE -> o_busy=1, o_ready=0, no o_submit. Release -> single o_submit pulse with correct data. Assert i_rst in CALC -> all outputs 0, IDLE.

Source files
------------

// File: rtl/execute_muldiv.sv
// Multi-cycle radix-2 multiply / divide / remainder unit that runs beside the single-cycle execute path.
// One shift-add or restoring shift-subtract step per cycle, optional two's-complement fix-up, back-pressure hold.
module execute_muldiv #(
  parameter int RW        = 16,
  parameter int REGNO     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_submit,
  output logic             o_ready,
  input  logic             i_flush,
  input  logic [RW-1:0]    i_a,
  input  logic [RW-1:0]    i_b,
  input  logic [1:0]       i_mode,
  input  logic             i_signed,
  input  logic [REGNO-1:0] i_reg_ie,
  output logic             o_busy,
  output logic [RW-1:0]    o_data,
  output logic [REGNO-1:0] o_reg_ie,
  output logic             o_submit,
  input  logic             i_next_ready
);

  localparam int DW = 2 * RW;
  localparam int CW = $clog2(RW + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    acc;
  logic [RW-1:0]    opnd;
  logic [1:0]       mode_q;
  logic             neg_res;
  logic             neg_rem;
  logic [REGNO-1:0] reg_ie_q;
  logic [RW-1:0]    result;

  logic          accept;
  logic          in_sgn;
  logic          a_neg;
  logic          b_neg;
  logic [RW-1:0] a_mag;
  logic [RW-1:0] b_mag;

  assign o_ready = (state == S_IDLE);
  assign o_busy  = (state != S_IDLE);
  assign accept  = (state == S_IDLE) && i_submit && !i_flush;

  // With SIGNED_EN cleared the sign path folds away to constants.
  assign in_sgn = SIGNED_EN && i_signed;
  assign a_neg  = in_sgn && i_a[RW-1];
  assign b_neg  = in_sgn && i_b[RW-1];
  assign a_mag  = a_neg ? (~i_a + RW'(1)) : i_a;
  assign b_mag  = b_neg ? (~i_b + RW'(1)) : i_b;

  logic [RW:0]   mul_sum;
  logic [DW-1:0] mul_next;
  logic [RW:0]   rem_sh;
  logic [RW:0]   div_diff;
  logic [DW-1:0] div_next;
  logic [DW-1:0] acc_next;
  logic [DW-1:0] prod_fix;
  logic [RW-1:0] quo_fix;
  logic [RW-1:0] rem_fix;
  logic [RW-1:0] final_res;

  // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[DW-1:RW]} + {1'b0, opnd & {RW{acc[0]}}};
    mul_next  = {mul_sum, acc[RW-1:1]};
    rem_sh    = {acc[DW-1:RW], acc[RW-1]};
    div_diff  = rem_sh - {1'b0, opnd};
    div_next  = div_diff[RW] ? {rem_sh[RW-1:0], acc[RW-2:0], 1'b0}
                             : {div_diff[RW-1:0], acc[RW-2:0], 1'b1};
    acc_next  = mode_q[1] ? div_next : mul_next;
    prod_fix  = neg_res ? (~acc_next + DW'(1)) : acc_next;
    quo_fix   = neg_res ? (~acc_next[RW-1:0] + RW'(1)) : acc_next[RW-1:0];
    rem_fix   = neg_rem ? (~acc_next[DW-1:RW] + RW'(1)) : acc_next[DW-1:RW];
    final_res = prod_fix[RW-1:0];
    case (mode_q)
      2'b00:   final_res = prod_fix[RW-1:0];
      2'b01:   final_res = prod_fix[DW-1:RW];
      2'b10:   final_res = quo_fix;
      default: final_res = rem_fix;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      mode_q   <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      reg_ie_q <= '0;
      result   <= '0;
      o_data   <= '0;
      o_reg_ie <= '0;
      o_submit <= 1'b0;
    end else begin
      o_submit <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mode_q   <= i_mode;
            reg_ie_q <= i_reg_ie;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            cnt      <= CW'(RW);
            // Divide by zero bypasses iteration; the remainder is the raw dividend.
            if (i_mode[1] && (i_b == '0)) begin
              result <= i_mode[0] ? i_a : '1;
              state  <= S_DONE;
            end else begin
              acc   <= {{RW{1'b0}}, (i_mode[1] ? a_mag : b_mag)};
              opnd  <= i_mode[1] ? b_mag : a_mag;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (i_flush) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              result <= final_res;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (i_flush) begin
            state <= S_IDLE;
          end else if (i_next_ready) begin
            o_data   <= result;
            o_reg_ie <= reg_ie_q;
            o_submit <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_execute_muldiv;

  localparam int RW    = 16;
  localparam int REGNO = 8;

  logic             i_clk;
  logic             i_rst;
  logic             i_submit;
  logic             o_ready;
  logic             i_flush;
  logic [RW-1:0]    i_a;
  logic [RW-1:0]    i_b;
  logic [1:0]       i_mode;
  logic             i_signed;
  logic [REGNO-1:0] i_reg_ie;
  logic             o_busy;
  logic [RW-1:0]    o_data;
  logic [REGNO-1:0] o_reg_ie;
  logic             o_submit;
  logic             i_next_ready;

  int checks = 0;
  int errors = 0;

  execute_muldiv #(.RW(RW), .REGNO(REGNO), .SIGNED_EN(1'b1)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_submit     (i_submit),
    .o_ready      (o_ready),
    .i_flush      (i_flush),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_mode       (i_mode),
    .i_signed     (i_signed),
    .i_reg_ie     (i_reg_ie),
    .o_busy       (o_busy),
    .o_data       (o_data),
    .o_reg_ie     (o_reg_ie),
    .o_submit     (o_submit),
    .i_next_ready (i_next_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: ordinary integer arithmetic on sign- or zero-extended operands.
  function automatic logic [RW-1:0] refModel(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                             input logic [1:0] mode, input logic sgn);
    longint     sa, sb, res;
    logic [63:0] bits;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    if (!mode[1]) begin
      res  = sa * sb;
      bits = res;
      return mode[0] ? bits[2*RW-1:RW] : bits[RW-1:0];
    end
    if (b == '0) return mode[0] ? a : {RW{1'b1}};
    res  = mode[0] ? (sa % sb) : (sa / sb);
    bits = res;
    return bits[RW-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offers one operation and returns just after the accept edge with inputs scrambled.
  task automatic applyStimulus(input logic [RW-1:0] a, input logic [RW-1:0] b, input logic [1:0] mode,
                               input logic sgn, input logic [REGNO-1:0] ie);
    checkOutput("ready_before_accept", 32'(o_ready), 32'd1);
    i_a = a; i_b = b; i_mode = mode; i_signed = sgn; i_reg_ie = ie; i_submit = 1'b1;
    @(posedge i_clk); #1;
    i_submit = 1'b0;
    i_a = RW'($urandom); i_b = RW'($urandom); i_mode = 2'($urandom);
    i_signed = 1'($urandom); i_reg_ie = REGNO'($urandom);
  endtask

  // Counts edges from the accept edge (edge 1) until o_submit is seen, bounded.
  task automatic waitSubmit(output int lat);
    lat = 1;
    while (o_submit !== 1'b1 && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [RW-1:0] a, input logic [RW-1:0] b,
                       input logic [1:0] mode, input logic sgn);
    logic [REGNO-1:0] ie;
    int lat;
    int exp_lat;
    ie = REGNO'(1) << $urandom_range(0, REGNO-1);
    exp_lat = (mode[1] && b == '0) ? 2 : RW + 2;
    applyStimulus(a, b, mode, sgn, ie);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd1);
    waitSubmit(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_data"}, 32'(o_data), 32'(refModel(a, b, mode, sgn)));
    checkOutput({tag, "_reg_ie"}, 32'(o_reg_ie), 32'(ie));
    @(posedge i_clk); #1;
    checkOutput({tag, "_pulse_end"}, 32'(o_submit), 32'd0);
  endtask

  initial begin
    logic ok;
    logic [RW-1:0] ra, rb;
    logic [1:0]    rm;
    logic          rs;

    i_rst = 1'b1; i_submit = 1'b0; i_flush = 1'b0; i_a = '0; i_b = '0;
    i_mode = '0; i_signed = 1'b0; i_reg_ie = '0; i_next_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checkOutput("rst_submit", 32'(o_submit), 32'd0);
    checkOutput("rst_data", 32'(o_data), 32'd0);
    checkOutput("rst_reg_ie", 32'(o_reg_ie), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_ready", 32'(o_ready), 32'd1);

    $display("[TB] directed arithmetic");
    runOp("mul_lo", 16'h1234, 16'h0010, 2'b00, 1'b0);
    runOp("mulh_u", 16'hFFFF, 16'hFFFF, 2'b01, 1'b0);
    runOp("mull_u", 16'hFFFF, 16'hFFFF, 2'b00, 1'b0);
    runOp("mulh_s", 16'hFFFF, 16'hFFFF, 2'b01, 1'b1);
    runOp("div_u", 16'd100, 16'd7, 2'b10, 1'b0);
    runOp("rem_u", 16'd100, 16'd7, 2'b11, 1'b0);
    runOp("div_s", 16'hFFF9, 16'd2, 2'b10, 1'b1);
    runOp("rem_s", 16'hFFF9, 16'd2, 2'b11, 1'b1);
    runOp("div_min", 16'h8000, 16'hFFFF, 2'b10, 1'b1);
    runOp("rem_min", 16'h8000, 16'hFFFF, 2'b11, 1'b1);
    runOp("div_zero", 16'h1234, 16'h0000, 2'b10, 1'b0);
    runOp("rem_zero", 16'h1234, 16'h0000, 2'b11, 1'b0);
    runOp("rem_zero_s", 16'hF234, 16'h0000, 2'b11, 1'b1);

    $display("[TB] flush during CALC");
    applyStimulus(16'd5000, 16'd3, 2'b10, 1'b0, 8'h04);
    repeat (4) @(posedge i_clk);
    #1;
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    checkOutput("flush_calc_ready", 32'(o_ready), 32'd1);
    checkOutput("flush_calc_busy", 32'(o_busy), 32'd0);
    ok = 1'b1;
    repeat (25) begin
      if (o_submit !== 1'b0) ok = 1'b0;
      @(posedge i_clk); #1;
    end
    checkOutput("flush_calc_no_submit", 32'(ok), 32'd1);
    runOp("after_flush", 16'd999, 16'd10, 2'b11, 1'b0);

    $display("[TB] flush with submit in IDLE");
    i_a = 16'd7; i_b = 16'd3; i_mode = 2'b00; i_submit = 1'b1; i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_submit = 1'b0; i_flush = 1'b0;
    checkOutput("flush_idle_ready", 32'(o_ready), 32'd1);
    checkOutput("flush_idle_busy", 32'(o_busy), 32'd0);

    $display("[TB] back-pressure hold");
    i_next_ready = 1'b0;
    applyStimulus(16'h0ABC, 16'h0013, 2'b00, 1'b0, 8'h20);
    repeat (RW + 1) @(posedge i_clk);
    #1;
    ok = 1'b1;
    repeat (10) begin
      if (!(o_busy === 1'b1 && o_ready === 1'b0 && o_submit === 1'b0)) ok = 1'b0;
      @(posedge i_clk); #1;
    end
    checkOutput("hold_done", 32'(ok), 32'd1);
    i_next_ready = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("release_submit", 32'(o_submit), 32'd1);
    checkOutput("release_data", 32'(o_data), 32'(refModel(16'h0ABC, 16'h0013, 2'b00, 1'b0)));
    checkOutput("release_reg_ie", 32'(o_reg_ie), 32'h20);
    @(posedge i_clk); #1;
    checkOutput("release_single", 32'(o_submit), 32'd0);

    $display("[TB] flush colliding with transfer");
    i_next_ready = 1'b0;
    applyStimulus(16'd40, 16'd6, 2'b10, 1'b0, 8'h01);
    repeat (RW + 1) @(posedge i_clk);
    #1;
    i_next_ready = 1'b1; i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    checkOutput("flush_done_submit", 32'(o_submit), 32'd0);
    checkOutput("flush_done_ready", 32'(o_ready), 32'd1);

    $display("[TB] random operations");
    for (int n = 0; n < 40; n++) begin
      ra = RW'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom);
      rm = 2'($urandom);
      rs = 1'($urandom);
      runOp("rand", ra, rb, rm, rs);
    end

    $display("[TB] reset during CALC");
    applyStimulus(16'h7777, 16'h0003, 2'b00, 1'b0, 8'h80);
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    checkOutput("rst_calc_data", 32'(o_data), 32'd0);
    checkOutput("rst_calc_reg_ie", 32'(o_reg_ie), 32'd0);
    checkOutput("rst_calc_submit", 32'(o_submit), 32'd0);
    checkOutput("rst_calc_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_calc_ready", 32'(o_ready), 32'd1);
    ok = 1'b1;
    repeat (RW + 4) begin
      if (o_submit !== 1'b0) ok = 1'b0;
      @(posedge i_clk); #1;
    end
    checkOutput("rst_calc_no_submit", 32'(ok), 32'd1);
    runOp("after_reset", 16'd12345, 16'd100, 2'b10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
